// File: rtl/idss_feeder.sv
// Groups a valid/ready pixel stream into 3-pixel column triples for four channel slots
// and sequences the downstream shift stage. Optional stall counter: IDSS_FEEDER_STALL_CNT_EN.
module idss_feeder #(
   parameter int IO_DATA_WIDTH      = 16,
   parameter int FEATURE_MAP_WIDTH  = 1024,
   parameter int FEATURE_MAP_HEIGHT = 1024,
   parameter int KERNEL_SIZE        = 3,
   parameter int NB_SLOTS           = 4
) (
   input  logic                     clk,
   input  logic                     rst_in,
   input  logic                     start_in,
   input  logic [IO_DATA_WIDTH-1:0] in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [IO_DATA_WIDTH-1:0] row_1,
   output logic [IO_DATA_WIDTH-1:0] row_2,
   output logic [IO_DATA_WIDTH-1:0] row_3,
   output logic [1:0]               LE_select,
   output logic                     load_out,
   output logic                     shift,
   output logic                     window_valid_out,
   output logic                     done_out,
   output logic                     busy_out,
   output logic [2:0]               state_out
`ifdef IDSS_FEEDER_STALL_CNT_EN
   ,output logic [31:0]             stall_cnt_out
`endif
);

   // Handshake: a beat transfers on a rising edge where in_valid && in_ready; upstream
   // holds in_data stable while in_valid && !in_ready. in_ready is high only in GATHER.

   localparam int CW = $clog2(FEATURE_MAP_WIDTH);
   localparam int SW = $clog2(FEATURE_MAP_HEIGHT);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] GATHER = 3'd1;
   localparam logic [2:0] LOAD   = 3'd2;
   localparam logic [2:0] SHIFT  = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;

   logic [2:0]               state;
   logic [1:0]               pix_idx;
   logic [1:0]               slot_idx;
   logic [1:0]               fill_cnt;
   logic [1:0]               fill_inc;
   logic [CW-1:0]            col_cnt;
   logic [SW-1:0]            strip_cnt;
   logic [IO_DATA_WIDTH-1:0] hold_0;
   logic [IO_DATA_WIDTH-1:0] hold_1;

   assign fill_inc  = (fill_cnt == 2'd3) ? 2'd3 : fill_cnt + 2'd1;

   assign in_ready  = (state == GATHER);
   assign load_out  = (state == LOAD);
   assign shift     = (state == SHIFT);
   assign done_out  = (state == DONE);
   assign busy_out  = (state != IDLE);
   assign state_out = state;

   always_ff @(posedge clk) begin
      if (rst_in) begin
         state            <= IDLE;
         pix_idx          <= '0;
         slot_idx         <= '0;
         fill_cnt         <= '0;
         col_cnt          <= '0;
         strip_cnt        <= '0;
         hold_0           <= '0;
         hold_1           <= '0;
         row_1            <= '0;
         row_2            <= '0;
         row_3            <= '0;
         LE_select        <= '0;
         window_valid_out <= 1'b0;
`ifdef IDSS_FEEDER_STALL_CNT_EN
         stall_cnt_out    <= '0;
`endif
      end else begin
         window_valid_out <= 1'b0;
         case (state)
            IDLE: begin
               if (start_in) begin
                  state     <= GATHER;
                  pix_idx   <= '0;
                  slot_idx  <= '0;
                  col_cnt   <= '0;
                  fill_cnt  <= '0;
                  strip_cnt <= '0;
`ifdef IDSS_FEEDER_STALL_CNT_EN
                  stall_cnt_out <= '0;
`endif
               end
            end
            GATHER: begin
               if (in_valid) begin
                  case (pix_idx)
                     2'd0: begin
                        hold_0  <= in_data;
                        pix_idx <= 2'd1;
                     end
                     2'd1: begin
                        hold_1  <= in_data;
                        pix_idx <= 2'd2;
                     end
                     default: begin
                        row_1     <= hold_0;
                        row_2     <= hold_1;
                        row_3     <= in_data;
                        LE_select <= slot_idx;
                        pix_idx   <= '0;
                        state     <= LOAD;
                     end
                  endcase
               end
`ifdef IDSS_FEEDER_STALL_CNT_EN
               else if (stall_cnt_out != 32'hFFFF_FFFF) begin
                  stall_cnt_out <= stall_cnt_out + 32'd1;
               end
`endif
            end
            LOAD: begin
               if (slot_idx == 2'(NB_SLOTS - 1)) begin
                  slot_idx <= '0;
                  state    <= SHIFT;
               end else begin
                  slot_idx <= slot_idx + 2'd1;
                  state    <= GATHER;
               end
            end
            SHIFT: begin
               // Flag uses the pre-wrap fill so the last column of a strip still reports.
               fill_cnt         <= fill_inc;
               window_valid_out <= (fill_inc == 2'd3);
               if (col_cnt == CW'(FEATURE_MAP_WIDTH - 1)) begin
                  col_cnt   <= '0;
                  fill_cnt  <= '0;
                  strip_cnt <= strip_cnt + 1'b1;
                  state     <= (strip_cnt == SW'(FEATURE_MAP_HEIGHT - KERNEL_SIZE)) ? DONE : GATHER;
               end else begin
                  col_cnt <= col_cnt + 1'b1;
                  state   <= GATHER;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_idss_feeder.sv
// Bench for idss_feeder: per-cycle vector table for the first column, scoreboard of
// expected triples, and hand sequences for backpressure, mid-frame reset and ignore rules.
module tb_idss_feeder;

   localparam int W   = 16;
   localparam int FMW = 4;
   localparam int FMH = 4;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_GATHER = 3'd1;

   logic          clk;
   logic          rst_in;
   logic          start_in;
   logic [W-1:0]  in_data;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  row_1, row_2, row_3;
   logic [1:0]    LE_select;
   logic          load_out, shift, window_valid_out, done_out, busy_out;
   logic [2:0]    state_out;
`ifdef IDSS_FEEDER_STALL_CNT_EN
   logic [31:0]   stall_cnt_out;
`endif

   idss_feeder #(
      .IO_DATA_WIDTH(W), .FEATURE_MAP_WIDTH(FMW), .FEATURE_MAP_HEIGHT(FMH),
      .KERNEL_SIZE(3), .NB_SLOTS(4)
   ) dut (
      .clk(clk), .rst_in(rst_in), .start_in(start_in), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .row_1(row_1), .row_2(row_2),
      .row_3(row_3), .LE_select(LE_select), .load_out(load_out), .shift(shift),
      .window_valid_out(window_valid_out), .done_out(done_out), .busy_out(busy_out),
      .state_out(state_out)
`ifdef IDSS_FEEDER_STALL_CNT_EN
      , .stall_cnt_out(stall_cnt_out)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit         v;
      bit         e_rdy;
      bit         e_load;
      bit         e_shift;
      logic [2:0] e_state;
   } vec_t;

   vec_t          tbl[17];
   logic [49:0]   exp_q[$];
   int            n_chk, n_fail;
   int            beats, trip, hcnt;
   int            load_cnt, shift_cnt, done_cnt, fshift;
   logic [W-1:0]  pix, h0, h1;
   bit            mon_en, wv_exp, prev_le3;
   time           t_start, done_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // driver tasks
   task automatic do_reset();
      @(negedge clk);
      mon_en   = 0;
      rst_in   = 1;
      in_valid = 0;
      start_in = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_in   = 0;
      hcnt     = 0;
      trip     = 0;
      pix      = '0;
      fshift   = 0;
      wv_exp   = 0;
      prev_le3 = 0;
      exp_q.delete();
      mon_en   = 1;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_row_1"}, row_1, 0);
      chk({tag, "_row_2"}, row_2, 0);
      chk({tag, "_row_3"}, row_3, 0);
      chk({tag, "_le_select"}, LE_select, 0);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_load"}, load_out, 0);
      chk({tag, "_shift"}, shift, 0);
      chk({tag, "_window"}, window_valid_out, 0);
      chk({tag, "_done"}, done_out, 0);
      chk({tag, "_busy"}, busy_out, 0);
      chk({tag, "_state"}, state_out, S_IDLE);
   endtask

   task automatic start_frame();
      @(negedge clk);
      start_in = 1;
      in_valid = 0;
      @(posedge clk);
      t_start = $time;
      #1;
      start_in = 0;
      fshift = 0;
   endtask

   task automatic step(input bit v, input bit s);
      @(negedge clk);
      in_valid = v;
      start_in = s;
      in_data  = pix;
      #1;
      if (v && in_ready) begin
         beats++;
         if (hcnt == 2) begin
            exp_q.push_back({h0, h1, pix, trip[1:0]});
            trip++;
            hcnt = 0;
         end else if (hcnt == 0) begin
            h0 = pix;
            hcnt = 1;
         end else begin
            h1 = pix;
            hcnt = 2;
         end
         pix++;
      end
   endtask

   // runs the rest of a frame with in_valid held high and checks the frame totals
   task automatic finish_frame(input string tag, input int b_load, input int b_shift,
                               input int b_beats, input int b_done);
      int  k;
      time cyc;
      for (k = 0; k < 300 && done_cnt == b_done; k++) step(1, (k == 20) || (k == 55));
      if (done_cnt == b_done) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s_done_timeout: no done_out within 300 cycles", tag);
      end
      cyc = (done_t - t_start + 5) / 10;
      chk({tag, "_done_cycle"}, cyc, 137);
      step(1, 0);
      chk({tag, "_busy_after"}, busy_out, 0);
      chk({tag, "_state_after"}, state_out, S_IDLE);
      step(1, 0);
      chk({tag, "_load_count"}, load_cnt - b_load, 32);
      chk({tag, "_shift_count"}, shift_cnt - b_shift, 8);
      chk({tag, "_beat_count"}, beats - b_beats, 96);
      chk({tag, "_done_count"}, done_cnt - b_done, 1);
      chk({tag, "_queue_empty"}, exp_q.size(), 0);
   endtask

   initial begin
      int b_load, b_shift, b_beats, b_done;
      logic [49:0] e;
      n_chk = 0; n_fail = 0; beats = 0; load_cnt = 0; shift_cnt = 0; done_cnt = 0;
      done_t = 0; t_start = 0; mon_en = 0; wv_exp = 0; prev_le3 = 0;
      rst_in = 1; start_in = 0; in_valid = 0; in_data = '0;
      pix = '0; h0 = '0; h1 = '0; hcnt = 0; trip = 0; fshift = 0;

      // first column, cycles 1..17 after start: three GATHER cycles then LOAD per slot, then SHIFT
      for (int k = 1; k <= 17; k++) begin
         tbl[k-1].v       = 1;
         tbl[k-1].e_rdy   = (k <= 16) && (k % 4 != 0);
         tbl[k-1].e_load  = (k <= 16) && (k % 4 == 0);
         tbl[k-1].e_shift = (k == 17);
         tbl[k-1].e_state = (k == 17) ? 3'd3 : ((k % 4 == 0) ? 3'd2 : 3'd1);
      end

      // scoreboard monitor
      fork
         forever begin
            @(negedge clk);
            if (mon_en) begin
               chk("window_valid", window_valid_out, wv_exp);
               wv_exp = 0;
               if (load_out) begin
                  load_cnt++;
                  if (exp_q.size() == 0) begin
                     n_chk++;
                     n_fail++;
                     $display("FAIL load_unexpected: load_out with no pending triple at %0t", $time);
                  end else begin
                     e = exp_q.pop_front();
                     chk("load_triple", {row_1, row_2, row_3, LE_select}, e);
                  end
               end
               if (shift) begin
                  shift_cnt++;
                  fshift++;
                  chk("shift_after_slot3", prev_le3, 1);
                  wv_exp = (((fshift - 1) % FMW) + 1) >= 3;
               end
               prev_le3 = load_out && (LE_select == 2'd3);
               if (done_out) begin
                  done_cnt++;
                  done_t = $time;
               end
            end
         end
      join_none

      // reset then a full frame, with start_in pulses while busy
      do_reset();
      chk_reset_state("reset");
      step(0, 0);
      chk("idle_no_ready", in_ready, 0);
      b_load = load_cnt; b_shift = shift_cnt; b_beats = beats; b_done = done_cnt;
      start_frame();
      for (int i = 0; i < 17; i++) begin
         step(tbl[i].v, 0);
         chk("vec_in_ready", in_ready, tbl[i].e_rdy);
         chk("vec_load", load_out, tbl[i].e_load);
         chk("vec_shift", shift, tbl[i].e_shift);
         chk("vec_state", state_out, tbl[i].e_state);
      end
      finish_frame("frame1", b_load, b_shift, b_beats, b_done);

      // backpressure: 5-cycle gap after the first beat
      do_reset();
      start_frame();
      step(1, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 0);
         chk("stall_state", state_out, S_GATHER);
         chk("stall_no_load", load_out, 0);
      end
      step(1, 0);
      step(1, 0);
      step(0, 0);
      chk("stall_load", load_out, 1);
      chk("stall_row_3", row_3, 2);
`ifdef IDSS_FEEDER_STALL_CNT_EN
      chk("stall_cnt", stall_cnt_out, 5);
`endif

      // reset during slot 2 of column 1, then a clean restart
      do_reset();
      start_frame();
      repeat (27) step(1, 0);
      chk("pre_reset_busy", busy_out, 1);
      do_reset();
      chk_reset_state("midreset");
      b_load = load_cnt; b_shift = shift_cnt; b_beats = beats; b_done = done_cnt;
      start_frame();
      finish_frame("restart", b_load, b_shift, b_beats, b_done);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
